// File: rtl/pc_fetch_pkg.sv
// Shared encodings for the PC/fetch sequencer: FSM states and next-PC selects.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_BRC  = 3'd2,
    SEL_BRZ  = 3'd3,
    SEL_JMP  = 3'd4,
    SEL_CALL = 3'd5,
    SEL_RET  = 3'd6,
    SEL_HALT = 3'd7
  } sel_e;

endpackage

// File: rtl/pc_fetch_stack.sv
// Hardware return stack: LIFO of STACK_DEPTH return addresses with full/empty flags.
module pc_stack
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH-1:0] din_i,
  output logic [ADDR_WIDTH-1:0] dout_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PW:0]           sp_q;
  logic [PW:0]           sp_d;
  logic [PW-1:0]         top_idx_s;

  // sp counts valid entries; the top entry sits one below it
  assign top_idx_s = sp_q[PW-1:0] - PW'(1);
  assign dout_o    = mem_q[top_idx_s];
  assign full_o    = (sp_q == FULL_CNT);
  assign empty_o   = (sp_q == {(PW+1){1'b0}});

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + (PW+1)'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - (PW+1)'(1);
    end else begin
      sp_d = sp_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sp_q <= {(PW+1){1'b0}};
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[sp_q[PW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer: request/ack instruction fetch, next-PC
// selection and a small hardware return stack.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 9,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    STACK_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  exec_done,
  input  logic [2:0]            next_sel,
  input  logic [ADDR_WIDTH-1:0] result0,
  input  logic [ADDR_WIDTH-1:0] resultc,
  input  logic [ADDR_WIDTH-1:0] resultz,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  halted,
  output logic                  stack_err
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  stack_err_q, stack_err_d;
  logic                  mem_rd_q, halted_q;
  logic                  push_s, pop_s;
  logic [ADDR_WIDTH-1:0] pc_inc_s, stack_top_s;
  logic                  stack_full_s, stack_empty_s;

  assign pc_inc_s = pc_q + ADDR_WIDTH'(1);

  pc_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (pc_inc_s),
    .dout_o  (stack_top_s),
    .full_o  (stack_full_s),
    .empty_o (stack_empty_s)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    stack_err_d   = stack_err_q;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (mem_ack) begin
          instr_d       = mem_data;
          instr_valid_d = 1'b1;
          state_d       = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          instr_valid_d = 1'b0;
          state_d       = ST_FETCH;
          case (sel_e'(next_sel))
            SEL_SEQ:  pc_d = pc_inc_s;
            SEL_BR:   pc_d = result0;
            SEL_BRC:  pc_d = resultc;
            SEL_BRZ:  pc_d = resultz;
            SEL_JMP:  pc_d = jump_addr;
            SEL_CALL: begin
              // A call that cannot be pushed stops the core with pc intact
              if (stack_full_s) begin
                stack_err_d = 1'b1;
                state_d     = ST_HALTED;
              end else begin
                push_s = 1'b1;
                pc_d   = jump_addr;
              end
            end
            SEL_RET: begin
              if (stack_empty_s) begin
                stack_err_d = 1'b1;
                state_d     = ST_HALTED;
              end else begin
                pop_s = 1'b1;
                pc_d  = stack_top_s;
              end
            end
            SEL_HALT: state_d = ST_HALTED;
            default:  state_d = ST_HALTED;
          endcase
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_HALTED: begin
        state_d       = ST_HALTED;
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d       = ST_HALTED;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // Output flags are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_ADDR;
      instr_q       <= {DATA_WIDTH{1'b0}};
      instr_valid_q <= 1'b0;
      stack_err_q   <= 1'b0;
      mem_rd_q      <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      stack_err_q   <= stack_err_d;
      mem_rd_q      <= (state_d == ST_FETCH);
      halted_q      <= (state_d == ST_HALTED);
    end
  end

  assign pc          = pc_q;
  assign mem_addr    = pc_q;
  assign mem_rd      = mem_rd_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign stack_err   = stack_err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus random stimulus, all checked every
// cycle against a phase/queue reference model of the fetch sequencer.
module tb_pc_fetch;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int SD = 4;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] pc;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          exec_done = 1'b0;
  logic [2:0]    next_sel = 3'd0;
  logic [AW-1:0] result0 = '0;
  logic [AW-1:0] resultc = '0;
  logic [AW-1:0] resultz = '0;
  logic [AW-1:0] jump_addr = '0;
  logic          halted;
  logic          stack_err;

  always #5 clk = ~clk;

  pc_fetch #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STACK_DEPTH (SD),
    .RESET_ADDR  (9'h000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc          (pc),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .next_sel    (next_sel),
    .result0     (result0),
    .resultc     (resultc),
    .resultz     (resultz),
    .jump_addr   (jump_addr),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: phase 0 idle, 1 fetch, 2 exec, 3 halted
  int m_ph    = 0;
  int m_pc    = 0;
  int m_instr = 0;
  bit m_iv    = 1'b0;
  bit m_err   = 1'b0;
  int m_stack[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step();
    if (reset) begin
      m_ph = 0; m_pc = 0; m_instr = 0; m_iv = 1'b0; m_err = 1'b0;
      m_stack.delete();
    end else begin
      case (m_ph)
        0: if (start) m_ph = 1;
        1: if (mem_ack) begin
             m_instr = int'(mem_data); m_iv = 1'b1; m_ph = 2;
           end
        2: if (exec_done) begin
             m_iv = 1'b0;
             m_ph = 1;
             case (int'(next_sel))
               0: m_pc = (m_pc + 1) & AMASK;
               1: m_pc = int'(result0);
               2: m_pc = int'(resultc);
               3: m_pc = int'(resultz);
               4: m_pc = int'(jump_addr);
               5: if (m_stack.size() == SD) begin
                    m_err = 1'b1; m_ph = 3;
                  end else begin
                    m_stack.push_back((m_pc + 1) & AMASK);
                    m_pc = int'(jump_addr);
                  end
               6: if (m_stack.size() == 0) begin
                    m_err = 1'b1; m_ph = 3;
                  end else begin
                    m_pc = m_stack.pop_back();
                  end
               default: m_ph = 3;
             endcase
           end
        default: ;
      endcase
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("mem_rd", 32'(mem_rd), 32'(m_ph == 1));
    if (m_ph == 1) chk("mem_addr", 32'(mem_addr), 32'(m_pc));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("instr_valid", 32'(instr_valid), 32'(m_iv));
    chk("halted", 32'(halted), 32'(m_ph == 3));
    chk("stack_err", 32'(stack_err), 32'(m_err));
  endtask

  task automatic cyc(input bit rs, input bit st, input bit ak, input bit dn,
                     input int sel, input int a);
    reset     = rs;
    start     = st;
    mem_ack   = ak;
    exec_done = dn;
    next_sel  = 3'(sel);
    jump_addr = AW'(a);
    result0   = AW'(a);
    resultc   = AW'(a);
    resultz   = AW'(a);
    mem_data  = DW'($urandom);
    tick();
  endtask

  task automatic fa();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic ex(input int sel, input int a);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, sel, a);
  endtask

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
    repeat (4) begin fa(); ex(0, 0); end
    chk("seq_pc4", 32'(pc), 32'h4);

    fa(); ex(4, 'h1FF);
    chk("jmp_1ff", 32'(pc), 32'h1FF);
    fa(); ex(0, 0);
    chk("seq_wrap", 32'(mem_addr), 32'h000);

    fa(); ex(1, 'h0F0);
    chk("br", 32'(pc), 32'h0F0);
    fa(); ex(4, 0);
    fa(); ex(2, 'h0F0);
    chk("brc", 32'(pc), 32'h0F0);
    fa(); ex(3, 'h0F0);
    chk("brz_refetch", 32'(mem_addr), 32'h0F0);

    fa(); ex(4, 'h010);
    fa(); ex(5, 'h050);
    chk("call", 32'(pc), 32'h050);
    fa(); ex(6, 0);
    chk("ret", 32'(pc), 32'h011);

    for (int i = 0; i < 5; i++) begin fa(); ex(5, 'h100 + i); end
    chk("ovf_err", 32'(stack_err), 32'h1);
    chk("ovf_halt", 32'(halted), 32'h1);
    chk("ovf_pc", 32'(pc), 32'h103);
    repeat (6) cyc(1'b0, 1'b1, 1'b1, 1'b1, 5, 'h055);
    chk("halt_hold_pc", 32'(pc), 32'h103);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("slow_rd", 32'(mem_rd), 32'h1);
    mem_data = 16'hBEEF;
    reset = 1'b0; start = 1'b0; mem_ack = 1'b1; exec_done = 1'b0;
    tick();
    chk("slow_instr", 32'(instr), 32'hBEEF);
    ex(0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    chk("rst_rd", 32'(mem_rd), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, 4, 'h1AA);
    chk("done_in_fetch", 32'(pc), 32'h0);
    fa(); ex(7, 0);
    chk("halt_sel", 32'(halted), 32'h1);

    for (int n = 0; n < 1500; n++) begin
      int r;
      reset     = (m_ph == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      start     = 1'($urandom);
      mem_ack   = ($urandom_range(0, 2) == 0);
      exec_done = 1'($urandom);
      r         = $urandom_range(0, 15);
      next_sel  = (r < 8) ? 3'd0 : 3'(r - 8);
      if ($urandom_range(0, 3) == 0) r = $urandom_range(0, 15) + 9'h1F0;
      else                           r = $urandom_range(0, AMASK);
      jump_addr = AW'(r);
      result0   = AW'($urandom);
      resultc   = $urandom_range(0, 1) ? AW'(m_pc) : AW'($urandom);
      resultz   = $urandom_range(0, 1) ? AW'(m_pc) : AW'($urandom);
      mem_data  = DW'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
